pll_reconfig_seq: RTL and testbench

Sequencer that retunes the core's fractional PLL at run time through the Altera PLL reconfiguration IP's Avalon-MM slave. It accepts one M/N/K/C0 request over a valid/ready handshake and writes the reconfig registers in a fixed order. It then waits for the PLL to report a stable lock and reports done or error. It sits between the core's video/CPU clock-select logic and the reconfig IP, on the 50 MHz reference clock domain.

---
 rtl/pll_reconfig_pkg.sv | 74 +++++++
 rtl/pll_lock_monitor.sv | 58 +++++
 rtl/pll_reconfig_seq.sv | 153 +++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
// Holds the reconfig register map, the sequencer state encoding, the Avalon
// write payload type and the helper that maps a write state to its register word.
package pll_reconfig_pkg;

    localparam int unsigned CW       = 18;  // M/N/C counter word width
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CSEL_LSB = 18;  // C counter-select field [22:18]
    localparam int unsigned CSEL_W   = 5;

    localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_START = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_N     = 6'h03;
    localparam logic [ADDR_W-1:0] ADDR_M     = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_C     = 6'h05;
    localparam logic [ADDR_W-1:0] ADDR_K     = 6'h07;

    typedef enum logic [3:0] {
        IDLE,
        WR_MODE,
        WR_N,
        WR_M,
        WR_K,
        WR_C,
        WR_START,
        SETTLE,
        WAIT_LOCK,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } avm_wr_t;

    // Register word issued in a given write state; zero outside the write states.
    function automatic avm_wr_t reg_write(input state_t s,
                                          input logic [CW-1:0] m,
                                          input logic [CW-1:0] n,
                                          input logic [CW-1:0] c0,
                                          input logic [DATA_W-1:0] k);
        avm_wr_t wr;
        wr = '0;
        case (s)
            WR_MODE:  wr.addr = ADDR_MODE;  // data 0 selects waitrequest mode
            WR_N: begin
                wr.addr = ADDR_N;
                wr.data = DATA_W'(n);
            end
            WR_M: begin
                wr.addr = ADDR_M;
                wr.data = DATA_W'(m);
            end
            WR_K: begin
                wr.addr = ADDR_K;
                wr.data = k;
            end
            WR_C: begin
                wr.addr = ADDR_C;
                wr.data = DATA_W'(c0);
                wr.data[CSEL_LSB +: CSEL_W] = CSEL_W'(0);  // counter C0
            end
            WR_START: begin
                wr.addr = ADDR_START;
                wr.data = DATA_W'(1);
            end
            default: wr = '0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Lock qualification counters for the PLL reconfiguration sequencer.
// Ports: clk, rst_n (sync, active-low), clear (hold counters at zero),
// pll_locked (synchronised lock), stable_hit / timeout_hit (threshold reached
// on the current edge).
module pll_lock_monitor
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic pll_locked,
    output logic stable_hit,
    output logic timeout_hit
);

    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] timeout_q, timeout_d;

    // Saturating counters; stable restarts on any lock drop, timeout never does.
    always_comb begin
        stable_d  = stable_q;
        timeout_d = timeout_q;
        if (clear) begin
            stable_d  = '0;
            timeout_d = '0;
        end else begin
            if (!pll_locked) begin
                stable_d = '0;
            end else if (stable_q != SW'(LOCK_STABLE)) begin
                stable_d = stable_q + SW'(1);
            end
            if (timeout_q != TW'(LOCK_TIMEOUT)) begin
                timeout_d = timeout_q + TW'(1);
            end
        end
    end

    // Hits look at the count this edge produces so the FSM leaves on that same edge.
    assign stable_hit  = !clear && pll_locked && (stable_q >= SW'(LOCK_STABLE - 1));
    assign timeout_hit = !clear && (timeout_q >= TW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_q  <= '0;
            timeout_q <= '0;
        end else begin
            stable_q  <= stable_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Run-time retune sequencer for the fractional PLL via the reconfig IP's Avalon-MM slave.
// Ports: clk, rst_n (sync, active-low); cfg_valid/cfg_ready request handshake with
// cfg_m/cfg_n/cfg_c0 counter words and cfg_k fractional M; avm_* write-only master;
// pll_locked (synchronised); busy, done (pulse), error (sticky until next accept).
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_STABLE   = 256,
    parameter int unsigned LOCK_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_c0,
    input  logic [31:0] cfg_k,
    output logic [5:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned STW = $clog2(SETTLE_CYCLES + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     m_q, m_d, n_q, n_d, c0_q, c0_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic [STW-1:0]    settle_q, settle_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              avm_write_q, avm_write_d;
    avm_wr_t           wr_q, wr_d;
    logic              lock_clear;
    logic              stable_hit, timeout_hit;

    assign lock_clear = (state_q != WAIT_LOCK);

    pll_lock_monitor #(
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_lock_monitor (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (lock_clear),
        .pll_locked (pll_locked),
        .stable_hit (stable_hit),
        .timeout_hit(timeout_hit)
    );

    // Next state; outputs are derived from state_d so they are registered with it.
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        c0_d     = c0_q;
        k_d      = k_q;
        settle_d = '0;
        done_d   = 1'b0;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    m_d     = cfg_m;
                    n_d     = cfg_n;
                    c0_d    = cfg_c0;
                    k_d     = cfg_k;
                    error_d = 1'b0;
                    state_d = WR_MODE;
                end
            end
            // Each write state holds until the slave drops waitrequest.
            WR_MODE:  if (!avm_waitrequest) state_d = WR_N;
            WR_N:     if (!avm_waitrequest) state_d = WR_M;
            WR_M:     if (!avm_waitrequest) state_d = WR_K;
            WR_K:     if (!avm_waitrequest) state_d = WR_C;
            WR_C:     if (!avm_waitrequest) state_d = WR_START;
            WR_START: if (!avm_waitrequest) state_d = SETTLE;
            SETTLE: begin
                if (settle_q == STW'(SETTLE_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                end else begin
                    settle_d = settle_q + STW'(1);
                end
            end
            WAIT_LOCK: begin
                // Success has priority over a simultaneous timeout.
                if (stable_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_d        = reg_write(state_d, m_d, n_d, c0_d, k_d);
        avm_write_d = (state_d inside {WR_MODE, WR_N, WR_M, WR_K, WR_C, WR_START});
        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            c0_q        <= '0;
            k_q         <= '0;
            settle_q    <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            avm_write_q <= 1'b0;
            wr_q        <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            c0_q        <= c0_d;
            k_q         <= k_d;
            settle_q    <= settle_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            avm_write_q <= avm_write_d;
            wr_q        <= wr_d;
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign avm_write     = avm_write_q;
    assign avm_address   = wr_q.addr;
    assign avm_writedata = wr_q.data;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: directed scenarios plus randomized
// requests, all compared against a cycle-count/register-list reference model.
module tb_pll_reconfig_seq;

    localparam int S   = 16;
    localparam int L   = 256;
    localparam int TO  = 1000;
    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [17:0] cfg_m, cfg_n, cfg_c0;
    logic [31:0] cfg_k;
    logic [5:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        pll_locked;
    logic        busy, done, error;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    pll_reconfig_seq #(
        .SETTLE_CYCLES(S),
        .LOCK_STABLE  (L),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_m          (cfg_m),
        .cfg_n          (cfg_n),
        .cfg_c0         (cfg_c0),
        .cfg_k          (cfg_k),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .pll_locked     (pll_locked),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference register list: {addr, data} for write index i.
    function automatic logic [37:0] exp_wr(input int i, input logic [17:0] m, input logic [17:0] n,
                                           input logic [17:0] c, input logic [31:0] k);
        case (i)
            0:       return {6'h00, 32'h0000_0000};
            1:       return {6'h03, 14'b0, n};
            2:       return {6'h04, 14'b0, m};
            3:       return {6'h07, k};
            4:       return {6'h05, 9'b0, 5'b0, c};
            default: return {6'h02, 32'h0000_0001};
        endcase
    endfunction

    // One request end to end. Sample index kr counts cycles after the accept edge
    // (kr=1 is the first). glitch_off < 0 means no glitch.
    task automatic run_op(input string tag, input logic [17:0] m, input logic [17:0] n,
                          input logic [17:0] c, input logic [31:0] k, input int stall_pct,
                          input int m_stall, input int glitch_off, input bit no_lock);
        int nwr, stalls, m_left, done_k, done_cnt, err_k, ready_k, ws, exp_done, exp_end;
        bit prev_stall, ended, ws_known;
        logic [37:0] prev, cur;
        logic wr;
        nwr = 0; stalls = 0; m_left = m_stall; done_k = -1; done_cnt = 0;
        err_k = -1; ready_k = -1; ws = 0; prev_stall = 0; ended = 0; ws_known = 0;
        prev = '0;

        @(negedge clk);
        chk({tag, "_ready_idle"}, 64'(cfg_ready), 64'(1));
        cfg_m = m; cfg_n = n; cfg_c0 = c; cfg_k = k; cfg_valid = 1'b1;
        avm_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;

        for (int kr = 1; kr <= BUDGET; kr++) begin
            @(negedge clk);
            cur = {avm_address, avm_writedata};
            if (kr == 1) chk({tag, "_error_cleared"}, 64'(error), 64'(0));
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = kr;
            end
            if (error && err_k < 0) err_k = kr;
            if (cfg_ready) begin
                ready_k = kr;
                cfg_valid = 1'b0;
                ended = 1;
                break;
            end
            chk({tag, "_busy"}, 64'(busy), 64'(1));
            if (prev_stall) chk({tag, "_hold"}, {25'b0, avm_write, cur}, {25'b0, 1'b1, prev});

            // Slave behaviour: stall only while a write is presented.
            if (avm_write) begin
                wr = 1'b0;
                if (avm_address == 6'h04 && m_left > 0) begin
                    wr = 1'b1;
                    m_left--;
                end else if (int'($urandom_range(99)) < stall_pct) begin
                    wr = 1'b1;
                end
                avm_waitrequest = wr;
                if (wr) begin
                    stalls++;
                    prev = cur;
                    prev_stall = 1;
                end else begin
                    prev_stall = 0;
                    if (nwr < 6) chk({tag, "_write"}, 64'(cur), 64'(exp_wr(nwr, m, n, c, k)));
                    nwr++;
                    if (nwr == 6) begin
                        ws = 7 + S + stalls;
                        ws_known = 1;
                    end
                end
            end else begin
                prev_stall = 0;
                avm_waitrequest = 1'($urandom_range(1));
            end

            // Lock ignored before WAIT_LOCK, so drive noise there.
            if (!ws_known || kr < ws) pll_locked = 1'($urandom_range(1));
            else if (no_lock) pll_locked = 1'b0;
            else if (glitch_off >= 0 && kr == ws + glitch_off) pll_locked = 1'b0;
            else pll_locked = 1'b1;

            // Busy-time garbage on the request inputs must be ignored.
            cfg_valid = 1'($urandom_range(1));
            cfg_m = 18'($urandom); cfg_n = 18'($urandom);
            cfg_c0 = 18'($urandom); cfg_k = $urandom;
        end
        avm_waitrequest = 1'b0;
        cfg_valid = 1'b0;

        if (no_lock) begin
            exp_done = -1;
            exp_end  = ws + TO + 1;
        end else if (glitch_off >= 0) begin
            exp_done = ws + glitch_off + 257;
            exp_end  = exp_done + 1;
        end else begin
            exp_done = ws + L;
            exp_end  = exp_done + 1;
        end
        chk({tag, "_ended"}, 64'(ended), 64'(1));
        chk({tag, "_nwrites"}, 64'(nwr), 64'(6));
        chk({tag, "_done_cycle"}, 64'(done_k), 64'(exp_done));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'(no_lock ? 0 : 1));
        chk({tag, "_ready_cycle"}, 64'(ready_k), 64'(exp_end));
        if (no_lock) chk({tag, "_err_cycle"}, 64'(err_k), 64'(ws + TO));
        else chk({tag, "_no_error"}, 64'(err_k), 64'(-1));
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; avm_waitrequest = 1'b0; pll_locked = 1'b0;
        cfg_m = '0; cfg_n = '0; cfg_c0 = '0; cfg_k = '0;

        // Reset state after three reset cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(cfg_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_write", 64'(avm_write), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_addr_data", {26'b0, avm_address, avm_writedata}, 64'(0));
        rst_n = 1'b1;

        // Nominal: no stalls, locked high; done at 279.
        run_op("nominal", 18'h00808, 18'h00101, 18'h00505, 32'h147AE148, 0, 0, -1, 0);

        // Four waitrequest cycles on WR_M; done at 283.
        run_op("stall", 18'h00808, 18'h00101, 18'h00505, 32'h147AE148, 0, 4, -1, 0);

        // One-cycle lock drop after 200 stable cycles.
        run_op("glitch", 18'h20A0B, 18'h00302, 18'h10707, 32'hDEADBEEF, 0, 0, 200, 0);

        // Lock never arrives: error after TO cycles, sticky in idle.
        run_op("timeout", 18'h01234, 18'h00202, 18'h00303, 32'h00000001, 0, 0, -1, 1);
        repeat (3) @(negedge clk);
        chk("error_sticky", 64'(error), 64'(1));

        // Next request clears error (checked inside) and completes.
        run_op("after_err", 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 32'hFFFFFFFF, 20, 0, -1, 0);

        // Reset during SETTLE.
        @(negedge clk);
        cfg_m = 18'($urandom); cfg_n = 18'($urandom); cfg_c0 = 18'($urandom); cfg_k = $urandom;
        cfg_valid = 1'b1; avm_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("midop_busy_before", 64'(busy), 64'(1));
        chk("midop_nowrite_settle", 64'(avm_write), 64'(0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midop_ready", 64'(cfg_ready), 64'(1));
        chk("midop_busy", 64'(busy), 64'(0));
        chk("midop_write", 64'(avm_write), 64'(0));
        chk("midop_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        run_op("after_rst", 18'h00808, 18'h00101, 18'h00505, 32'h147AE148, 0, 0, -1, 0);

        // Randomized requests with random slave stalls.
        for (int i = 0; i < 4; i++) begin
            run_op("rand", 18'($urandom), 18'($urandom), 18'($urandom), $urandom,
                   30, int'($urandom_range(3)), -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
